// File: rtl/sys_array_stream_ctrl.sv
// -----------------------------------------------------------------------------
// sys_array_stream_ctrl
//
// Host-side initiator for the systolic-array fetcher. Bytes arriving on the
// input stream are assembled into the fetcher's weight (W) and activation (A)
// buses. The block then strobes load_params / start_comp, waits for the
// fetcher's result, and streams the product matrix back out with a last flag.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   start, reuse_w      job request; reuse_w skips the W load if weights resident
//   s_valid/s_ready/s_data          input byte stream
//   m_valid/m_ready/m_data/m_last   result stream (2*DATA_WIDTH per element)
//   load_params, start_comp         one-cycle strobes to the fetcher
//   data_a, data_w                  operand buses to the fetcher
//   arr_ready, arr_data             result handshake/bus from the fetcher
//   busy, error                     job in progress / sticky timeout flag
//   dbg_state_o                     current FSM state for checkers
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both 1. s_ready and m_valid are decoded from the registered state only, so
// neither depends combinationally on its partner (s_valid / m_ready); an
// unaccepted beat is simply held by the sender and state does not move.
// -----------------------------------------------------------------------------
module sys_array_stream_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ARRAY_A_W      = 4,
  parameter int ARRAY_A_L      = 3,
  parameter int ARRAY_W_W      = 3,
  parameter int ARRAY_W_L      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                                    clk,
  input  logic                                                    reset_n,
  input  logic                                                    start,
  input  logic                                                    reuse_w,
  input  logic                                                    s_valid,
  output logic                                                    s_ready,
  input  logic [DATA_WIDTH-1:0]                                   s_data,
  output logic                                                    m_valid,
  input  logic                                                    m_ready,
  output logic [2*DATA_WIDTH-1:0]                                 m_data,
  output logic                                                    m_last,
  output logic                                                    load_params,
  output logic                                                    start_comp,
  output logic [0:ARRAY_A_W-1][ARRAY_A_L-1:0][DATA_WIDTH-1:0]     data_a,
  output logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]     data_w,
  input  logic                                                    arr_ready,
  input  logic [0:ARRAY_A_W-1][0:ARRAY_W_L-1][2*DATA_WIDTH-1:0]   arr_data,
  output logic                                                    busy,
  output logic                                                    error,
  output logic [2:0]                                              dbg_state_o
);

  localparam int NW    = ARRAY_W_W * ARRAY_W_L;
  localparam int NA    = ARRAY_A_W * ARRAY_A_L;
  localparam int NR    = ARRAY_A_W * ARRAY_W_L;
  localparam int NMAX  = (NW > NA) ? ((NW > NR) ? NW : NR) : ((NA > NR) ? NA : NR);
  localparam int CNT_W = $clog2(NMAX) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_PARAM  = 3'd2,
    ST_LOAD_A = 3'd3,
    ST_START  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_DRAIN  = 3'd6
  } state_e;

  state_e                                                   state_q, state_d;
  logic [CNT_W-1:0]                                         cnt_q, cnt_d;
  logic [TMO_W-1:0]                                         wait_q, wait_d;
  logic                                                     w_loaded_q, w_loaded_d;
  logic                                                     error_q, error_d;
  logic [0:ARRAY_A_W-1][ARRAY_A_L-1:0][DATA_WIDTH-1:0]      data_a_q, data_a_d;
  logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]      data_w_q, data_w_d;
  logic [0:ARRAY_A_W-1][0:ARRAY_W_L-1][2*DATA_WIDTH-1:0]    res_q, res_d;

  logic s_fire;
  logic m_fire;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  // State register plus all datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      w_loaded_q <= 1'b0;
      error_q    <= 1'b0;
      data_a_q   <= '0;
      data_w_q   <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      w_loaded_q <= w_loaded_d;
      error_q    <= error_d;
      data_a_q   <= data_a_d;
      data_w_q   <= data_w_d;
      res_q      <= res_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (reuse_w && w_loaded_q) ? ST_LOAD_A : ST_LOAD_W;
      end
      ST_LOAD_W: begin
        if (s_fire && cnt_q == CNT_W'(NW - 1)) state_d = ST_PARAM;
      end
      ST_PARAM: state_d = ST_LOAD_A;
      ST_LOAD_A: begin
        if (s_fire && cnt_q == CNT_W'(NA - 1)) state_d = ST_START;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // The fetcher's ready from the previous job is still up on the first
        // WAIT cycle, so only accept arr_ready once wait_q has advanced.
        if (wait_q != '0 && arr_ready)                  state_d = ST_DRAIN;
        else if (wait_q == TMO_W'(TIMEOUT_CYCLES - 1))  state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (m_fire && cnt_q == CNT_W'(NR - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    cnt_d      = cnt_q;
    wait_d     = '0;
    w_loaded_d = w_loaded_q;
    error_d    = error_q;
    data_a_d   = data_a_q;
    data_w_d   = data_w_q;
    res_d      = res_q;

    // One beat counter serves LOAD_W, LOAD_A and DRAIN; it restarts on every
    // state change so each phase counts from zero.
    if (state_d != state_q)    cnt_d = '0;
    else if (s_fire || m_fire) cnt_d = cnt_q + 1'b1;

    if (state_q == ST_WAIT && state_d == ST_WAIT) wait_d = wait_q + 1'b1;

    if (state_q == ST_IDLE && start)              error_d = 1'b0;
    // Leaving WAIT straight to IDLE only happens on timeout. Weights stay
    // resident, so w_loaded is left alone.
    if (state_q == ST_WAIT && state_d == ST_IDLE) error_d = 1'b1;

    if (state_q == ST_PARAM) w_loaded_d = 1'b1;

    if (state_q == ST_LOAD_W && s_fire) begin
      for (int r = 0; r < ARRAY_W_W; r++) begin
        for (int c = 0; c < ARRAY_W_L; c++) begin
          if (cnt_q == CNT_W'(r * ARRAY_W_L + c)) data_w_d[r][c] = s_data;
        end
      end
    end

    if (state_q == ST_LOAD_A && s_fire) begin
      for (int r = 0; r < ARRAY_A_W; r++) begin
        for (int c = 0; c < ARRAY_A_L; c++) begin
          if (cnt_q == CNT_W'(r * ARRAY_A_L + c)) data_a_d[r][c] = s_data;
        end
      end
    end

    if (state_q == ST_WAIT && state_d == ST_DRAIN) res_d = arr_data;
  end

  // Outputs decoded from registered state only.
  always_comb begin
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = '0;
    load_params = 1'b0;
    start_comp  = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_LOAD_W, ST_LOAD_A: s_ready = 1'b1;
      ST_PARAM:             load_params = 1'b1;
      ST_START:             start_comp  = 1'b1;
      ST_DRAIN: begin
        m_valid = 1'b1;
        m_last  = (cnt_q == CNT_W'(NR - 1));
        for (int r = 0; r < ARRAY_A_W; r++) begin
          for (int c = 0; c < ARRAY_W_L; c++) begin
            if (cnt_q == CNT_W'(r * ARRAY_W_L + c)) m_data = res_q[r][c];
          end
        end
      end
      default: ;
    endcase
  end

  assign data_a      = data_a_q;
  assign data_w      = data_w_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule
